ps2_datain: RTL and testbench

Receives device-to-host PS/2 frames (keyboard scan codes, mouse packets) and delivers them as validated bytes. This is the receive half of the PS/2 port. It shares the pre-synchronised PS/2 clock-edge strobes and data level with the host-to-device command transmitter. It checks start, odd parity and stop bits, and enforces an inter-bit timeout. The receiver is gated off by `enable` while the transmitter owns the bus.

---
 rtl/ps2_datain.sv | 93 +++++++++
 tb/tb_ps2_datain.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_datain.sv
// PS/2 device-to-host receiver: start/parity/stop checks and inter-bit timeout.
// Shares the synchronised PS/2 clock-edge strobe and data level with the command transmitter.
module ps2_datain #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_BITS   = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       error_parity,
  output logic       error_framing,
  output logic       error_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] TO_MAX =
    TIMEOUT_BITS'(TIMEOUT_CYCLES);

  state_t                  state;
  logic [7:0]              shift;
  logic [2:0]              bit_cnt;
  logic                    par_bit;
  logic [TIMEOUT_BITS-1:0] to_cnt;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    received_data_en <= 1'b0;
    error_parity     <= 1'b0;
    error_framing    <= 1'b0;
    error_timeout    <= 1'b0;
    if (reset) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      received_data <= 8'h00;
    end else if (!enable) begin
      // Transmitter owns the bus: drop any partial frame silently.
      state   <= IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
      if (ps2_clk_negedge && !ps2_data) begin
        state   <= DATA;
        bit_cnt <= '0;
      end
    end else if (ps2_clk_negedge) begin
      to_cnt <= '0;
      case (state)
        DATA: begin
          shift   <= {ps2_data, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY: begin
          par_bit <= ps2_data;
          state   <= STOP;
        end
        STOP: begin
          error_parity  <= ~^{shift, par_bit};
          error_framing <= ~ps2_data;
          if ((^{shift, par_bit}) && ps2_data) begin
            received_data    <= shift;
            received_data_en <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (to_cnt == TO_MAX) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      error_timeout <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_datain.sv
// Randomised self-checking bench for ps2_datain against a frame-level model.
// Inputs change 1 ns after the rising edge; outputs are read at that point.
module tb_ps2_datain;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       ps2_clk_negedge;
  logic       ps2_data;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       error_parity;
  logic       error_framing;
  logic       error_timeout;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_en = 0, n_par = 0, n_frm = 0, n_to = 0;
  logic [7:0] last_good = 8'h00;

  ps2_datain #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_BITS(17)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ps2_clk_negedge(ps2_clk_negedge),
    .ps2_data(ps2_data),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .error_parity(error_parity),
    .error_framing(error_framing),
    .error_timeout(error_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    n_en  += int'(received_data_en);
    n_par += int'(error_parity);
    n_frm += int'(error_framing);
    n_to  += int'(error_timeout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic negedge_bit(input logic d, input int gap);
    ps2_data        = d;
    ps2_clk_negedge = 1'b1;
    tick();
    ps2_clk_negedge = 1'b0;
    ps2_data        = 1'b1;
    repeat (gap - 1) tick();
  endtask

  // Returns right after the edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int gap);
    negedge_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) negedge_bit(d[i], gap);
    negedge_bit(par, gap);
    negedge_bit(stop, 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    ps2_clk_negedge = 1'b0;
    ps2_data = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (received_data !== 8'h00) $display("FAIL reset_data got %h want 00", received_data);
    else pass_cnt++;
    total_cnt++;
    if ({busy, received_data_en, error_parity, error_framing, error_timeout} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
        {busy, received_data_en, error_parity, error_framing, error_timeout});
    else pass_cnt++;
  endtask

  task automatic test_good_frame();
    negedge_bit(1'b0, 20);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL good_busy_rise got %b want 1", busy);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) negedge_bit(logic'((8'h1C >> i) & 1), 20);
    negedge_bit(1'b0, 20);
    negedge_bit(1'b1, 1);
    total_cnt++;
    if ({received_data_en, received_data} !== {1'b1, 8'h1C})
      $display("FAIL good_data got en=%b %h want en=1 1c", received_data_en, received_data);
    else pass_cnt++;
    total_cnt++;
    if ({busy, error_parity, error_framing, error_timeout} !== 4'b0)
      $display("FAIL good_flags got %b want 0000",
        {busy, error_parity, error_framing, error_timeout});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (received_data_en !== 1'b0) $display("FAIL good_en_width got %b want 0", received_data_en);
    else pass_cnt++;
    last_good = 8'h1C;
  endtask

  task automatic test_parity();
    send_frame(8'hA5, 1'b1, 1'b1, 7);
    tick();
    send_frame(8'h1C, 1'b1, 1'b1, 7);
    total_cnt++;
    if ({error_parity, error_framing, received_data_en} !== 3'b100)
      $display("FAIL parity_strobes got %b want 100",
        {error_parity, error_framing, received_data_en});
    else pass_cnt++;
    total_cnt++;
    if (received_data !== 8'hA5) $display("FAIL parity_hold got %h want a5", received_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (error_parity !== 1'b0) $display("FAIL parity_width got %b want 0", error_parity);
    else pass_cnt++;
    last_good = 8'hA5;
  endtask

  task automatic test_framing();
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    total_cnt++;
    if ({error_framing, error_parity, received_data_en} !== 3'b100)
      $display("FAIL framing_strobes got %b want 100",
        {error_framing, error_parity, received_data_en});
    else pass_cnt++;
    tick();
    send_frame(8'hF0, 1'b1, 1'b1, 5);
    total_cnt++;
    if ({received_data_en, received_data} !== {1'b1, 8'hF0})
      $display("FAIL framing_recover got en=%b %h want en=1 f0", received_data_en, received_data);
    else pass_cnt++;
    last_good = 8'hF0;
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    tick();
    negedge_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) negedge_bit(logic'((8'h1C >> i) & 1), 20);
    negedge_bit(1'b1, 1);
    for (int i = 0; i < TO; i++) begin
      if (error_timeout || !busy) early = 1'b1;
      tick();
    end
    total_cnt++;
    if (early || error_timeout !== 1'b0)
      $display("FAIL timeout_early got early=%b to=%b want 0 0", early, error_timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({error_timeout, busy} !== 2'b10)
      $display("FAIL timeout_pulse got to=%b busy=%b want 1 0", error_timeout, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (error_timeout !== 1'b0) $display("FAIL timeout_width got %b want 0", error_timeout);
    else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1, 9);
    total_cnt++;
    if ({received_data_en, received_data} !== {1'b1, 8'h1C})
      $display("FAIL timeout_recover got en=%b %h want en=1 1c", received_data_en, received_data);
    else pass_cnt++;
    last_good = 8'h1C;
  endtask

  task automatic test_abort();
    int e0, p0, f0, t0;
    tick();
    e0 = n_en; p0 = n_par; f0 = n_frm; t0 = n_to;
    negedge_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) negedge_bit(logic'((8'h1C >> i) & 1), 4);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) negedge_bit(1'b1, 4);
    tick();
    total_cnt++;
    if ({busy, n_en - e0, n_par - p0, n_frm - f0, n_to - t0} !== {1'b0, 128'd0})
      $display("FAIL abort_quiet got busy=%b en=%0d par=%0d frm=%0d to=%0d want all 0",
        busy, n_en - e0, n_par - p0, n_frm - f0, n_to - t0);
    else pass_cnt++;
    negedge_bit(1'b0, 4);
    for (int i = 0; i < 3; i++) negedge_bit(1'b1, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if ({busy, received_data_en, error_parity, error_framing, error_timeout, received_data}
        !== 13'd0)
      $display("FAIL abort_reset got busy=%b data=%h", busy, received_data);
    else pass_cnt++;
    send_frame(8'hA5, 1'b1, 1'b1, 3);
    total_cnt++;
    if ({received_data_en, received_data} !== {1'b1, 8'hA5})
      $display("FAIL abort_recover got en=%b %h want en=1 a5", received_data_en, received_data);
    else pass_cnt++;
    last_good = 8'hA5;
  endtask

  task automatic test_idle_noise();
    logic bad;
    int e0;
    bad = 1'b0;
    tick();
    e0 = n_en + n_par + n_frm + n_to;
    for (int i = 0; i < 5; i++) begin
      negedge_bit(1'b1, 3);
      if (busy) bad = 1'b1;
    end
    total_cnt++;
    if (bad || (n_en + n_par + n_frm + n_to) != e0)
      $display("FAIL idle_noise got busy_seen=%b strobes=%0d want 0 0",
        bad, n_en + n_par + n_frm + n_to - e0);
    else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1, 3);
    total_cnt++;
    if ({received_data_en, received_data} !== {1'b1, 8'h1C})
      $display("FAIL idle_noise_frame got en=%b %h want en=1 1c", received_data_en, received_data);
    else pass_cnt++;
    last_good = 8'h1C;
  endtask

  // Frames follow each other with a start bit one cycle after the stop bit.
  task automatic test_back_to_back();
    logic [7:0] d;
    logic par, stop, good, perr, ferr;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      par  = ($urandom_range(0, 3) == 0) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 != 0);
      par  = ~par;
      stop = ($urandom_range(0, 3) != 0);
      perr = (($countones(d) + int'(par)) % 2) == 0;
      ferr = !stop;
      good = !perr && !ferr;
      if (good) last_good = d;
      send_frame(d, par, stop, $urandom_range(1, 45));
      total_cnt++;
      if ({received_data_en, error_parity, error_framing, error_timeout, received_data}
          !== {good, perr, ferr, 1'b0, last_good})
        $display("FAIL b2b_frame%0d got en=%b p=%b f=%b t=%b %h want en=%b p=%b f=%b t=0 %h",
          n, received_data_en, error_parity, error_framing, error_timeout, received_data,
          good, perr, ferr, last_good);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_timeout();
    test_abort();
    test_idle_noise();
    test_back_to_back();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
